// File: rtl/nx_stream_distributor.sv
// nx_stream_distributor: fans one valid/ready stream out to N/E/S/W.
// Optional drop counter enabled by defining NX_STREAM_DIST_DROP_CNT_EN.
module nx_stream_distributor #(
    parameter int    STREAM_WIDTH = 31,
    parameter string SKID_BUFFERS = "yes"
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [STREAM_WIDTH-1:0] dist_data_i,
    input  logic [1:0]              dist_dir_i,
    input  logic                    dist_valid_i,
    output logic                    dist_ready_o,
`ifdef NX_STREAM_DIST_DROP_CNT_EN
    output logic [15:0]             drop_count_o,
`endif
    output logic [STREAM_WIDTH-1:0] north_data_o,
    output logic                    north_valid_o,
    input  logic                    north_ready_i,
    input  logic                    north_present_i,
    output logic [STREAM_WIDTH-1:0] east_data_o,
    output logic                    east_valid_o,
    input  logic                    east_ready_i,
    input  logic                    east_present_i,
    output logic [STREAM_WIDTH-1:0] south_data_o,
    output logic                    south_valid_o,
    input  logic                    south_ready_i,
    input  logic                    south_present_i,
    output logic [STREAM_WIDTH-1:0] west_data_o,
    output logic                    west_valid_o,
    input  logic                    west_ready_i,
    input  logic                    west_present_i
);

    logic [3:0]              present;
    logic [3:0]              ready_in;
    logic [3:0]              valid_out;
    logic [STREAM_WIDTH-1:0] data_out [4];
    logic                    tgt_present;

    assign present  = {west_present_i, south_present_i,
                       east_present_i, north_present_i};
    assign ready_in = {west_ready_i, south_ready_i,
                       east_ready_i, north_ready_i};
    assign tgt_present = present[dist_dir_i];

    assign north_data_o  = data_out[0];
    assign east_data_o   = data_out[1];
    assign south_data_o  = data_out[2];
    assign west_data_o   = data_out[3];
    assign north_valid_o = valid_out[0];
    assign east_valid_o  = valid_out[1];
    assign south_valid_o = valid_out[2];
    assign west_valid_o  = valid_out[3];

    generate
        if (SKID_BUFFERS == "no") begin : g_comb
            // Pure pass-through: only the selected, present side sees valid.
            assign dist_ready_o = tgt_present ? ready_in[dist_dir_i] : 1'b1;
            for (genvar d = 0; d < 4; d++) begin : g_dir
                assign data_out[d]  = dist_data_i;
                assign valid_out[d] = dist_valid_i & present[d]
                                    & (dist_dir_i == 2'(d));
            end
        end else begin : g_skid
            logic [1:0] cnt [4];

            // Absent targets always accept so the message is swallowed.
            assign dist_ready_o = tgt_present ? (cnt[dist_dir_i] != 2'd2)
                                              : 1'b1;

            for (genvar d = 0; d < 4; d++) begin : g_dir
                logic [STREAM_WIDTH-1:0] head_q;
                logic [STREAM_WIDTH-1:0] tail_q;
                logic [1:0]              cnt_q;
                logic                    push;
                logic                    pop;

                assign push = dist_valid_i & dist_ready_o & present[d]
                            & (dist_dir_i == 2'(d));
                assign pop  = (cnt_q != 2'd0) & ready_in[d];

                assign cnt[d]       = cnt_q;
                assign data_out[d]  = head_q;
                assign valid_out[d] = cnt_q != 2'd0;

                // Two-entry FIFO; the head register drives the output directly.
                always_ff @(posedge clk_i or negedge rst_i) begin
                    if (!rst_i) begin
                        head_q <= '0;
                        tail_q <= '0;
                        cnt_q  <= 2'd0;
                    end else begin
                        case ({push, pop})
                            2'b10: begin
                                if (cnt_q == 2'd0) head_q <= dist_data_i;
                                else               tail_q <= dist_data_i;
                                cnt_q <= cnt_q + 2'd1;
                            end
                            2'b01: begin
                                head_q <= tail_q;
                                cnt_q  <= cnt_q - 2'd1;
                            end
                            2'b11: begin
                                if (cnt_q == 2'd1) begin
                                    head_q <= dist_data_i;
                                end else begin
                                    head_q <= tail_q;
                                    tail_q <= dist_data_i;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    endgenerate

`ifdef NX_STREAM_DIST_DROP_CNT_EN
    logic drop;
    assign drop = dist_valid_i & ~tgt_present;

    // Saturating tally of messages swallowed for lack of a neighbour.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            drop_count_o <= 16'd0;
        else if (drop && drop_count_o != 16'hFFFF)
            drop_count_o <= drop_count_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_nx_stream_distributor.sv
// Directed bench for nx_stream_distributor (skid and pass-through builds).
// Covers drop counter when NX_STREAM_DIST_DROP_CNT_EN is defined.
module tb_nx_stream_distributor;

    localparam int W = 31;

    logic         clk;
    logic         rst_i;
    logic [W-1:0] dist_data;
    logic [1:0]   dist_dir;
    logic         dist_valid;
    logic [3:0]   rdy;
    logic [3:0]   pres;

    logic         s_ready;
    logic [W-1:0] s_data [4];
    logic [3:0]   s_valid;
    logic         n_ready;
    logic [W-1:0] n_data [4];
    logic [3:0]   n_valid;
`ifdef NX_STREAM_DIST_DROP_CNT_EN
    logic [15:0]  s_drop;
    logic [15:0]  n_drop;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    nx_stream_distributor #(.STREAM_WIDTH(W), .SKID_BUFFERS("yes")) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .dist_data_i(dist_data), .dist_dir_i(dist_dir),
        .dist_valid_i(dist_valid), .dist_ready_o(s_ready),
`ifdef NX_STREAM_DIST_DROP_CNT_EN
        .drop_count_o(s_drop),
`endif
        .north_data_o(s_data[0]), .north_valid_o(s_valid[0]),
        .north_ready_i(rdy[0]), .north_present_i(pres[0]),
        .east_data_o(s_data[1]), .east_valid_o(s_valid[1]),
        .east_ready_i(rdy[1]), .east_present_i(pres[1]),
        .south_data_o(s_data[2]), .south_valid_o(s_valid[2]),
        .south_ready_i(rdy[2]), .south_present_i(pres[2]),
        .west_data_o(s_data[3]), .west_valid_o(s_valid[3]),
        .west_ready_i(rdy[3]), .west_present_i(pres[3])
    );

    nx_stream_distributor #(.STREAM_WIDTH(W), .SKID_BUFFERS("no")) u_nos (
        .clk_i(clk), .rst_i(rst_i),
        .dist_data_i(dist_data), .dist_dir_i(dist_dir),
        .dist_valid_i(dist_valid), .dist_ready_o(n_ready),
`ifdef NX_STREAM_DIST_DROP_CNT_EN
        .drop_count_o(n_drop),
`endif
        .north_data_o(n_data[0]), .north_valid_o(n_valid[0]),
        .north_ready_i(rdy[0]), .north_present_i(pres[0]),
        .east_data_o(n_data[1]), .east_valid_o(n_valid[1]),
        .east_ready_i(rdy[1]), .east_present_i(pres[1]),
        .south_data_o(n_data[2]), .south_valid_o(n_valid[2]),
        .south_ready_i(rdy[2]), .south_present_i(pres[2]),
        .west_data_o(n_data[3]), .west_valid_o(n_valid[3]),
        .west_ready_i(rdy[3]), .west_present_i(pres[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i      = 1'b0;
        dist_data  = '0;
        dist_dir   = 2'd0;
        dist_valid = 1'b0;
        rdy        = 4'hF;
        pres       = 4'hF;
        #2;
        chk("rst_valids", 32'(s_valid), 32'h0);
        chk("rst_data_s", 32'(s_data[2]), 32'h0);
        tick();
        tick();
        rst_i = 1'b1;
        tick();

        // Single message to south, latency 1
        dist_data = 31'h1234; dist_dir = 2'd2; dist_valid = 1'b1;
        #1;
        chk("t1_ready", 32'(s_ready), 32'h1);
        tick();
        dist_valid = 1'b0;
        chk("t1_s_valid", 32'(s_valid[2]), 32'h1);
        chk("t1_s_data", 32'(s_data[2]), 32'h1234);
        chk("t1_others", 32'({s_valid[3], s_valid[1], s_valid[0]}), 32'h0);
        tick();
        chk("t1_drained", 32'(s_valid[2]), 32'h0);

        // Fill south while stalled
        rdy[2] = 1'b0;
        dist_data = 31'hA; dist_dir = 2'd2; dist_valid = 1'b1;
        #1;
        chk("fill_A_rdy", 32'(s_ready), 32'h1);
        tick();
        dist_data = 31'hB;
        #1;
        chk("fill_B_rdy", 32'(s_ready), 32'h1);
        tick();

        // South full; east must still accept
        dist_data = 31'h55; dist_dir = 2'd1;
        #1;
        chk("iso_rdy", 32'(s_ready), 32'h1);
        tick();
        chk("iso_e_valid", 32'(s_valid[1]), 32'h1);
        chk("iso_e_data", 32'(s_data[1]), 32'h55);

        // Third south message blocked
        dist_data = 31'hC; dist_dir = 2'd2;
        #1;
        chk("full_rdy", 32'(s_ready), 32'h0);
        chk("full_head", 32'(s_data[2]), 32'hA);
        tick();
        chk("full_hold", 32'(s_ready), 32'h0);
        chk("full_head2", 32'(s_data[2]), 32'hA);

        // Release south and drain in order
        rdy[2] = 1'b1;
        tick();
        chk("drain_B", 32'(s_data[2]), 32'hB);
        chk("drain_rdy", 32'(s_ready), 32'h1);
        tick();
        dist_valid = 1'b0;
        chk("drain_C", 32'(s_data[2]), 32'hC);
        chk("drain_C_v", 32'(s_valid[2]), 32'h1);
        tick();
        chk("drain_empty", 32'(s_valid[2]), 32'h0);

        // Absent west neighbour drops the message
        pres[3] = 1'b0;
        dist_data = 31'h77; dist_dir = 2'd3; dist_valid = 1'b1;
        #1;
        chk("drop_rdy", 32'(s_ready), 32'h1);
        chk("drop_nos_v", 32'(n_valid[3]), 32'h0);
        chk("drop_nos_rdy", 32'(n_ready), 32'h1);
`ifdef NX_STREAM_DIST_DROP_CNT_EN
        chk("drop_cnt0", 32'(s_drop), 32'h0);
`endif
        tick();
        dist_valid = 1'b0;
        chk("drop_w_v1", 32'(s_valid[3]), 32'h0);
`ifdef NX_STREAM_DIST_DROP_CNT_EN
        chk("drop_cnt1", 32'(s_drop), 32'h1);
        chk("drop_cnt1_n", 32'(n_drop), 32'h1);
`endif
        tick();
        chk("drop_w_v2", 32'(s_valid[3]), 32'h0);
        pres[3] = 1'b1;

        // Pass-through build: valid/ready follow combinationally
        dist_data = 31'h3C; dist_dir = 2'd0; dist_valid = 1'b1;
        rdy[0] = 1'b0;
        #1;
        chk("nos_v0", 32'(n_valid[0]), 32'h1);
        chk("nos_r0", 32'(n_ready), 32'h0);
        chk("nos_d0", 32'(n_data[0]), 32'h3C);
        chk("nos_e_v", 32'(n_valid[1]), 32'h0);
        rdy[0] = 1'b1;
        #1;
        chk("nos_r1", 32'(n_ready), 32'h1);
        rdy[0] = 1'b0;
        #1;
        chk("nos_r2", 32'(n_ready), 32'h0);
        dist_valid = 1'b0;
        #1;
        chk("nos_v_off", 32'(n_valid[0]), 32'h0);
        rdy[0] = 1'b1;
        tick();

        // Fill north, then reset mid-stream
        rdy[0] = 1'b0;
        dist_data = 31'h11; dist_dir = 2'd0; dist_valid = 1'b1;
        tick();
        dist_data = 31'h22;
        tick();
        dist_valid = 1'b0;
        chk("pre_rst_v", 32'(s_valid[0]), 32'h1);
        chk("pre_rst_d", 32'(s_data[0]), 32'h11);
        rst_i = 1'b0;
        #1;
        chk("rst_mid_v", 32'(s_valid), 32'h0);
        chk("rst_mid_d", 32'(s_data[0]), 32'h0);
        tick();
        chk("rst_hold_v", 32'(s_valid), 32'h0);
        rst_i = 1'b1;
        rdy[0] = 1'b1;
        tick();
        chk("post_rst_v", 32'(s_valid[0]), 32'h0);
        chk("post_rst_rdy", 32'(s_ready), 32'h1);
        dist_data = 31'h99; dist_dir = 2'd0; dist_valid = 1'b1;
        tick();
        dist_valid = 1'b0;
        chk("post_rst_v1", 32'(s_valid[0]), 32'h1);
        chk("post_rst_d1", 32'(s_data[0]), 32'h99);
        tick();
        chk("post_rst_end", 32'(s_valid[0]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
